// File: rtl/bus_pkg.sv
// Shared types for the multi-master bus arbiter.
// Arbiter FSM states, arbitration mode codes, select-width helper.
package bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  function automatic int msel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the masters and the bus arbiter.
// master: requester side; slave: arbiter side.
interface bus_arbiter_rr_if
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 3
);

  localparam int MSEL_W = msel_w(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] breq;
  logic [NUM_SLAVES-1:0]  sready;
  logic [NUM_MASTERS-1:0] bgrant;
  logic [MSEL_W-1:0]      msel;
  logic                   bus_busy;
  logic                   grant_timeout;

  modport master (
    output breq, sready,
    input  bgrant, msel, bus_busy, grant_timeout
  );

  modport slave (
    input  breq, sready,
    output bgrant, msel, bus_busy, grant_timeout
  );

endinterface

// File: rtl/arb_rr_pick.sv
// Combinational winner picker: round-robin after ptr or lowest index.
// Masked requesters are never picked.
module arb_rr_pick
  import bus_pkg::*;
#(
  parameter int N = 4,
  parameter int W = msel_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  arb_mode_e    mode,
  input  logic [N-1:0] mask,
  output logic         valid,
  output logic [W-1:0] winner
);

  logic [N-1:0] eligible;
  int           idx;

  assign eligible = req & ~mask;

  // Scan farthest first so the nearest eligible index wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = N; i >= 1; i--) begin
      if (mode == ARB_FIXED) idx = i - 1;
      else idx = (int'(ptr) + i) % N;
      if (eligible[idx[W-1:0]]) begin
        valid  = 1'b1;
        winner = W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter, round-robin or fixed priority, slave-ready gated.
// Optional grant watchdog enabled by defining GRANT_TIMEOUT_EN.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int NUM_SLAVES     = 3,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            rstn,
  bus_arbiter_rr_if.slave bus
);

  localparam int N      = NUM_MASTERS;
  localparam int MSEL_W = msel_w(N);
  localparam arb_mode_e MODE =
    (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

  if (N < 2 || N > 16 || NUM_SLAVES < 1 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("bus_arbiter_rr: illegal parameters");
  end

  state_e            state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [MSEL_W-1:0] msel_q, msel_d;
  logic [MSEL_W-1:0] ptr_q, ptr_d;
  logic              tmo_q, tmo_d;
  logic [N-1:0]      mask;
  logic              pick_valid;
  logic [MSEL_W-1:0] pick_idx;
  logic              own_req;
  logic              arb_go;
  logic              hold_expired;

  assign arb_go  = (|bus.breq) & (&bus.sready);
  assign own_req = |(bus.breq & grant_q);

  arb_rr_pick #(
    .N (N),
    .W (MSEL_W)
  ) u_pick (
    .req    (bus.breq),
    .ptr    (ptr_q),
    .mode   (MODE),
    .mask   (mask),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

`ifdef GRANT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     mask_q;

  assign hold_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mask         = mask_q;

  // Revoked owner sits out exactly one arbitration attempt.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      if (state_q == IDLE) cnt_q <= '0;
      else cnt_q <= cnt_q + 1'b1;
      if (state_q == GRANT && own_req && hold_expired)
        mask_q <= grant_q;
      else if (state_q == IDLE && arb_go)
        mask_q <= '0;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign mask         = '0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    msel_d  = msel_q;
    ptr_d   = ptr_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_go && pick_valid) begin
          state_d = GRANT;
          grant_d = N'(1) << pick_idx;
          msel_d  = pick_idx;
          ptr_d   = pick_idx;
        end
      end
      GRANT: begin
        if (!own_req) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (hold_expired) begin
          state_d = IDLE;
          grant_d = '0;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      msel_q  <= '0;
      ptr_q   <= MSEL_W'(N - 1);
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      msel_q  <= msel_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.bgrant        = grant_q;
  assign bus.msel          = msel_q;
  assign bus.bus_busy      = |grant_q;
  assign bus.grant_timeout = tmo_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: round-robin and fixed-priority instances.
// Directed scenarios plus random traffic against a behavioural model.
module tb_bus_arbiter_rr;

  localparam int NM = 4;
  localparam int NS = 3;
`ifdef GRANT_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NM-1:0] breq = '0;
  logic [NS-1:0] sready = '1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS)) bus_rr ();
  bus_arbiter_rr_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS)) bus_fx ();

  assign bus_rr.breq   = breq;
  assign bus_rr.sready = sready;
  assign bus_fx.breq   = breq;
  assign bus_fx.sready = sready;

  bus_arbiter_rr #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS),
    .ARB_MODE(0), .TIMEOUT_CYCLES(8)
  ) dut_rr (.clk(clk), .rstn(rstn), .bus(bus_rr));

  bus_arbiter_rr #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS),
    .ARB_MODE(1), .TIMEOUT_CYCLES(8)
  ) dut_fx (.clk(clk), .rstn(rstn), .bus(bus_fx));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    breq = '0;
    sready = '1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    breq = 4'b0010;
    step();
    tests++;
    if (bus_rr.bgrant !== 4'b0010) begin
      fails++;
      $display("FAIL pre_reset_grant got %b want 0010", bus_rr.bgrant);
    end
    #3;
    rstn = 1'b0;
    #1;
    tests++;
    if (bus_rr.bgrant !== 4'b0000 || bus_rr.bus_busy !== 1'b0 ||
        bus_rr.msel !== 2'd0 || bus_rr.grant_timeout !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_rr got g=%b b=%b m=%0d t=%b want 0000/0/0/0",
               bus_rr.bgrant, bus_rr.bus_busy, bus_rr.msel, bus_rr.grant_timeout);
    end
    tests++;
    if (bus_fx.bgrant !== 4'b0000 || bus_fx.bus_busy !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_fx got g=%b b=%b want 0000/0",
               bus_fx.bgrant, bus_fx.bus_busy);
    end
    breq = 4'b1111;
    #2;
    rstn = 1'b1;
    step();
    tests++;
    if (bus_rr.bgrant !== 4'b0001 || bus_rr.msel !== 2'd0) begin
      fails++;
      $display("FAIL first_after_reset got g=%b m=%0d want 0001/0",
               bus_rr.bgrant, bus_rr.msel);
    end
  endtask

  task automatic test_rr_fairness();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int hold_cnt = 0;
    int gap = 0;
    logic [NM-1:0] prev = '0;
    apply_reset();
    breq = 4'b1111;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      step();
      if (bus_rr.bgrant != 0 && prev == 0) begin
        order.push_back(int'(bus_rr.msel));
        tests++;
        if (bus_rr.bgrant !== (4'(1) << exp_order[order.size()-1])) begin
          fails++;
          $display("FAIL rr_order[%0d] got g=%b m=%0d want idx %0d",
                   order.size()-1, bus_rr.bgrant, bus_rr.msel,
                   exp_order[order.size()-1]);
        end
        if (order.size() > 1) begin
          tests++;
          if (gap !== 1) begin
            fails++;
            $display("FAIL rr_dead_cycle got %0d want 1", gap);
          end
        end
      end
      if (bus_rr.bgrant != 0) begin
        hold_cnt++;
        gap = 0;
      end else begin
        hold_cnt = 0;
        gap++;
      end
      breq = 4'b1111;
      if (hold_cnt == 3) breq[bus_rr.msel] = 1'b0;
      prev = bus_rr.bgrant;
    end
    tests++;
    if (order.size() != 5) begin
      fails++;
      $display("FAIL rr_fairness_timeout got %0d grants want 5", order.size());
    end
  endtask

  task automatic test_fixed();
    apply_reset();
    breq = 4'b1010;
    step();
    tests++;
    if (bus_fx.bgrant !== 4'b0010 || bus_fx.msel !== 2'd1) begin
      fails++;
      $display("FAIL fixed_grant got g=%b m=%0d want 0010/1",
               bus_fx.bgrant, bus_fx.msel);
    end
    step();
    breq = 4'b1000;
    step();
    tests++;
    if (bus_fx.bgrant !== 4'b0000 || bus_fx.msel !== 2'd1) begin
      fails++;
      $display("FAIL fixed_release got g=%b m=%0d want 0000/1",
               bus_fx.bgrant, bus_fx.msel);
    end
    breq = 4'b1010;
    step();
    tests++;
    if (bus_fx.bgrant !== 4'b0010) begin
      fails++;
      $display("FAIL fixed_regrant got %b want 0010", bus_fx.bgrant);
    end
  endtask

  task automatic test_gating_and_hold();
    apply_reset();
    sready = 3'b101;
    breq = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus_rr.bgrant !== 4'b0000 || bus_rr.bus_busy !== 1'b0) begin
        fails++;
        $display("FAIL gated[%0d] got g=%b b=%b want 0000/0",
                 i, bus_rr.bgrant, bus_rr.bus_busy);
      end
    end
    sready = 3'b111;
    step();
    tests++;
    if (bus_rr.bgrant !== 4'b0100 || bus_rr.msel !== 2'd2) begin
      fails++;
      $display("FAIL ungated got g=%b m=%0d want 0100/2",
               bus_rr.bgrant, bus_rr.msel);
    end
    breq = 4'b0101;
    sready = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus_rr.bgrant !== 4'b0100) begin
        fails++;
        $display("FAIL no_preempt[%0d] got %b want 0100", i, bus_rr.bgrant);
      end
    end
    sready = 3'b111;
    breq = 4'b0001;
    step();
    tests++;
    if (bus_rr.bgrant !== 4'b0000 || bus_rr.msel !== 2'd2) begin
      fails++;
      $display("FAIL hold_release got g=%b m=%0d want 0000/2",
               bus_rr.bgrant, bus_rr.msel);
    end
    step();
    tests++;
    if (bus_rr.bgrant !== 4'b0001) begin
      fails++;
      $display("FAIL wrap_grant got %b want 0001", bus_rr.bgrant);
    end
  endtask

`ifdef GRANT_TIMEOUT_EN
  task automatic test_timeout();
    int held = 0;
    int pulses = 0;
    apply_reset();
    breq = 4'b0010;
    step();
    breq = 4'b0011;
    if (bus_rr.bgrant == 4'b0010) held = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_rr.grant_timeout) pulses++;
      if (bus_rr.bgrant == 4'b0010) held++;
      else break;
    end
    tests++;
    if (held !== 8 || pulses !== 1) begin
      fails++;
      $display("FAIL timeout_hold got held=%0d pulses=%0d want 8/1", held, pulses);
    end
    step();
    tests++;
    if (bus_rr.bgrant !== 4'b0001 || bus_rr.grant_timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_next got g=%b t=%b want 0001/0",
               bus_rr.bgrant, bus_rr.grant_timeout);
    end
  endtask
`else
  task automatic test_no_timeout();
    int pulses = 0;
    apply_reset();
    breq = 4'b0010;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus_rr.grant_timeout) pulses++;
    end
    tests++;
    if (bus_rr.bgrant !== 4'b0010 || pulses !== 0) begin
      fails++;
      $display("FAIL hold_forever got g=%b pulses=%0d want 0010/0",
               bus_rr.bgrant, pulses);
    end
  endtask
`endif

  task automatic test_random();
    int own[2], last[2], ptr[2], excl[2], held[2];
    bit tmo[2];
    int w, c;
    logic [NM-1:0] g, exp_g;
    logic [1:0] m;
    logic bz, t;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      own[k] = -1; last[k] = 0; ptr[k] = NM - 1;
      excl[k] = -1; held[k] = 0; tmo[k] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      breq = 4'($urandom);
      for (int k = 0; k < 2; k++)
        if (own[k] >= 0 && $urandom_range(0, 9) < 8) breq[own[k]] = 1'b1;
      sready = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        tmo[k] = 0;
        if (own[k] < 0) begin
          if (breq != 0 && &sready) begin
            w = -1;
            for (int i = 1; i <= NM; i++) begin
              c = (k == 1) ? i - 1 : (ptr[k] + i) % NM;
              if (w < 0 && breq[c] && c != excl[k]) w = c;
            end
            excl[k] = -1;
            if (w >= 0) begin
              own[k] = w; last[k] = w; ptr[k] = w; held[k] = 1;
            end
          end
        end else if (!breq[own[k]]) begin
          own[k] = -1;
        end else if (TMO > 0 && held[k] == TMO) begin
          excl[k] = own[k]; own[k] = -1; tmo[k] = 1;
        end else begin
          held[k]++;
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        g  = (k == 0) ? bus_rr.bgrant : bus_fx.bgrant;
        m  = (k == 0) ? bus_rr.msel : bus_fx.msel;
        bz = (k == 0) ? bus_rr.bus_busy : bus_fx.bus_busy;
        t  = (k == 0) ? bus_rr.grant_timeout : bus_fx.grant_timeout;
        exp_g = (own[k] < 0) ? 4'b0000 : (4'(1) << own[k]);
        tests++;
        if (g !== exp_g || m !== 2'(last[k]) || bz !== (own[k] >= 0) ||
            t !== tmo[k]) begin
          fails++;
          $display("FAIL random[%0d] dut%0d got g=%b m=%0d b=%b t=%b want g=%b m=%0d b=%b t=%b",
                   cyc, k, g, m, bz, t, exp_g, last[k], own[k] >= 0, tmo[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_fixed();
    test_gating_and_hold();
`ifdef GRANT_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised successor to the fixed two-master serial-bus arbiter, for the next-generation multi-master interconnect.
- Arbitrates NUM_MASTERS bus requests in round-robin or fixed-priority order.
- Holds a grant for the full transaction and gates new grants on all slaves being ready.
- Drives the master-select index that steers the interconnect's master-side muxes.

Parameters:
- NUM_MASTERS, 4: number of requesting masters; legal range 2..16.
- NUM_SLAVES, 3: number of slave ready inputs.
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.
- TIMEOUT_CYCLES, 255: maximum grant hold in cycles. Used only with GRANT_TIMEOUT_EN.
- MSEL_W, derived: max(1, clog2(NUM_MASTERS)). Not user-set.

Ports:
- clk  in  1  bus clock
- rstn  in  1  asynchronous active-low reset
- breq  in  NUM_MASTERS  per-master bus request, level
- sready  in  NUM_SLAVES  per-slave ready; 1 = idle, can accept a transaction
- bgrant  out  NUM_MASTERS  one-hot grant, registered
- msel  out  MSEL_W  index of the current or last owner, registered
- bus_busy  out  1  high while any grant is held
- grant_timeout  out  1  one-cycle pulse when a grant is revoked by the watchdog

Behaviour:
- Reset (rstn low, asynchronous):
  - bgrant = 0, msel = 0, bus_busy = 0, grant_timeout = 0.
  - state = IDLE.
  - rr_ptr = NUM_MASTERS-1, so master 0 has first priority after reset.
- State IDLE:
  - Arbitrate when |breq is high and &sready is high.
  - Round-robin: winner is the first asserted breq scanning from rr_ptr+1 upward, modulo NUM_MASTERS.
  - Fixed priority: winner is the lowest asserted index.
  - On the next edge: bgrant[winner] = 1, msel = winner, rr_ptr = winner, bus_busy = 1, state -> GRANT.
  - Grant latency is exactly 1 cycle from the request being sampled.
  - With no request, or any sready low: remain in IDLE; msel keeps its last value.
- State GRANT:
  - Hold bgrant while breq[owner] = 1. Other requests are ignored; there is no preemption.
  - When breq[owner] = 0: next edge bgrant = 0, bus_busy = 0, state -> IDLE.
  - msel is unchanged on release.
- Re-arbitration: a minimum of one dead IDLE cycle separates consecutive grants. A new grant appears no earlier than 2 cycles after the owner drops breq.
- Simultaneous events: the owner dropping breq while other requests are pending is handled by one IDLE cycle, then a grant to the next requester in round-robin order.
- sready falling during GRANT: no effect on the current grant.
- Single requester: it is re-granted after each dead cycle. Round-robin never starves a continuously requesting master; each waits at most NUM_MASTERS-1 grants.
- Invariants:
  - $onehot0(bgrant) at all times.
  - bus_busy == |bgrant.
  - When bus_busy = 1, msel equals the index of the asserted bgrant bit.
- Reset mid-grant: all outputs clear immediately (asynchronous); rr_ptr returns to NUM_MASTERS-1.

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- Defined:
  - A hold counter clears on grant and increments each GRANT cycle.
  - When the count reaches TIMEOUT_CYCLES while breq[owner] is still high, the grant is revoked on the next edge.
  - In the same cycle as the revoke: grant_timeout = 1 for one cycle, state -> IDLE.
  - The revoked master is excluded for exactly one arbitration, so another requester wins if present.
- Undefined:
  - No counter is built; grant_timeout is tied to 0.
  - Grants are held indefinitely.

Decomposition:
- Shared package bus_pkg holds:
  - the arbiter state enum (IDLE, GRANT);
  - the ARB_MODE constants ARB_RR = 0 and ARB_FIXED = 1;
  - a clog2-based MSEL width function.
- Sub-module arb_rr_pick (combinational): inputs req vector, ptr, mode, mask; outputs valid and winner index. It is reused by a future slave-side read arbiter.

Test Plan:
- Reset mid-grant: reset asserted while bgrant = 0010 -> bgrant = 0000, bus_busy = 0 immediately; with breq = 1111 after release, master 0 is granted first.
- Round-robin fairness: breq = 1111 held; each owner releases after 3 cycles -> grant order 0,1,2,3,0; one dead cycle between grants; msel tracks each owner.
- Fixed priority: ARB_MODE = 1, breq = 1010 -> bgrant = 0010 and msel = 1 one cycle later; after release with breq still 1010, master 1 is granted again.
- Slave gating: sready = 101, breq = 0100 -> no grant; sready goes to 111 at cycle t -> bgrant = 0100 at t+1.
- Hold/no preemption: master 2 owns the bus, breq[0] rises -> bgrant stays 0100 until breq[2] = 0, then master 3 is granted if requesting, else master 0.
- GRANT_TIMEOUT_EN with TIMEOUT_CYCLES = 8: master 1 holds breq -> revoked after 8 grant cycles, grant_timeout pulses once; with breq = 0011, master 0 is granted next.
